// File: rtl/alu_cmd_queue.sv
// Issue stage in front of a 4-bit combinational ALU: a request FIFO feeds the
// ALU from its head, and the result is captured into a handshaked output register.
module alu_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_code,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic [1:0]       alu_code,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [4:0]       alu_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_result,
    output logic [1:0]       out_code,
    output logic [CNT_W-1:0] issue_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    logic [9:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic [9:0]       head;
    logic             head_vld;
    logic             push;
    logic             issue;

    assign in_ready = (count != FULL);
    assign head_vld = (count != '0);
    assign push     = in_valid & in_ready;
    assign issue    = head_vld & (~out_valid | out_ready);
    assign head     = mem[rd_ptr];

    // An empty queue drives zeros so stale storage never reaches the ALU.
    assign alu_code = head_vld ? head[9:8] : 2'b00;
    assign alu_a    = head_vld ? head[7:4] : 4'h0;
    assign alu_b    = head_vld ? head[3:0] : 4'h0;

    // Storage is data only; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_code, in_a, in_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            out_result <= 5'h00;
            out_code   <= 2'b00;
            issue_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (issue) begin
                rd_ptr     <= rd_ptr + 1'b1;
                out_result <= alu_c;
                out_code   <= head[9:8];
                out_valid  <= 1'b1;
                issue_cnt  <= issue_cnt + 1'b1;
            end else if (out_valid & out_ready) begin
                out_valid <= 1'b0;
            end

            unique case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// Randomized and directed bench for alu_cmd_queue against a queue-based
// transaction model; also stands in for the combinational ALU.
module tb_alu_cmd_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_code;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic [1:0]       alu_code;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [4:0]       alu_c;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_result;
    logic [1:0]       out_code;
    logic [CNT_W-1:0] issue_cnt;

    alu_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_a      (in_a),
        .in_b      (in_b),
        .alu_code  (alu_code),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_code  (out_code),
        .issue_cnt (issue_cnt)
    );

    function automatic logic [4:0] alu_ref(input logic [1:0] c, input logic [3:0] a,
                                           input logic [3:0] b);
        case (c)
            2'b00:   return {1'b0, a & b};
            2'b01:   return {1'b0, a | b};
            2'b10:   return {1'b0, a} - {1'b0, b};
            default: return {1'b0, a} + {1'b0, b};
        endcase
    endfunction

    assign alu_c = alu_ref(alu_code, alu_a, alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending requests, output register and issue counter.
    logic [9:0]       mq[$];
    logic             m_ov = 1'b0;
    logic [4:0]       m_res = 5'h00;
    logic [1:0]       m_code = 2'b00;
    logic [CNT_W-1:0] m_cnt = '0;
    int               n_pushed = 0;
    logic [CNT_W-1:0] prev_cnt = '0;
    logic             wrapped = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [9:0] h;
        check_val("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
        check_val("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            check_val("out_result", 32'(out_result), 32'(m_res));
            check_val("out_code", 32'(out_code), 32'(m_code));
        end
        check_val("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
        h = (mq.size() != 0) ? mq[0] : 10'h000;
        check_val("alu_code", 32'(alu_code), 32'(h[9:8]));
        check_val("alu_a", 32'(alu_a), 32'(h[7:4]));
        check_val("alu_b", 32'(alu_b), 32'(h[3:0]));
    endtask

    // Called at a falling edge: drive, advance model across the rising edge, compare.
    task automatic step(input logic v, input logic [1:0] c, input logic [3:0] a,
                        input logic [3:0] b, input logic rdy);
        logic       do_push;
        logic       do_iss;
        logic       do_drain;
        logic [9:0] e;
        in_valid  = v;
        in_code   = c;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
        do_push  = v && (mq.size() < DEPTH);
        do_iss   = (mq.size() != 0) && (!m_ov || rdy);
        do_drain = m_ov && rdy && (mq.size() == 0);
        @(posedge clk);
        if (do_iss) begin
            e      = mq.pop_front();
            m_res  = alu_ref(e[9:8], e[7:4], e[3:0]);
            m_code = e[9:8];
            m_ov   = 1'b1;
            m_cnt  = m_cnt + 1'b1;
        end else if (do_drain) begin
            m_ov = 1'b0;
        end
        if (do_push) begin
            mq.push_back({c, a, b});
            n_pushed++;
        end
        @(negedge clk);
        compare_all();
        if (prev_cnt == 8'hFF && issue_cnt == 8'h00) wrapped = 1'b1;
        prev_cnt = issue_cnt;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 4'h0, 4'h0, rdy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] mix_c [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [3:0] mix_a [4] = '{4'hC, 4'hC, 4'h3, 4'hF};
        logic [3:0] mix_b [4] = '{4'hA, 4'hA, 4'h5, 4'hF};
        logic [4:0] mix_r [4] = '{5'h08, 5'h0E, 5'h1E, 5'h1E};
        int guard;

        rst = 1'b1;
        in_valid = 1'b0; in_code = 2'b00; in_a = 4'h0; in_b = 4'h0; out_ready = 1'b0;
        #3;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_issue_cnt", 32'(issue_cnt), 32'd0);
        check_val("rst_out_result", 32'(out_result), 32'd0);
        check_val("rst_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        compare_all();

        // Single ADD: result visible after the second edge.
        step(1'b1, 2'b11, 4'hC, 4'hA, 1'b1);
        check_val("single_lat_early", 32'(out_valid), 32'd0);
        step(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);
        check_val("single_valid", 32'(out_valid), 32'd1);
        check_val("single_result", 32'(out_result), 32'h16);
        check_val("single_code", 32'(out_code), 32'd3);
        check_val("single_cnt", 32'(issue_cnt), 32'd1);

        // Back-to-back mixed ops, one result per cycle.
        step(1'b1, mix_c[0], mix_a[0], mix_b[0], 1'b1);
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) step(1'b1, mix_c[i], mix_a[i], mix_b[i], 1'b1);
            else       step(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);
            check_val("mixed_valid", 32'(out_valid), 32'd1);
            check_val("mixed_result", 32'(out_result), 32'(mix_r[i-1]));
        end
        idle(2, 1'b1);

        // Backpressure: 4 queued plus 1 held in the output register.
        for (int i = 0; i < 5; i++)
            step(1'b1, 2'(i), 4'(i + 1), 4'(2 * i), 1'b0);
        check_val("bp_full", 32'(in_ready), 32'd0);
        step(1'b1, 2'b10, 4'h9, 4'h4, 1'b0);
        step(1'b1, 2'b10, 4'h9, 4'h4, 1'b0);
        check_val("bp_held", 32'(out_result), 32'(alu_ref(2'b00, 4'h1, 4'h0)));
        step(1'b1, 2'b10, 4'h9, 4'h4, 1'b1);
        idle(8, 1'b1);

        // Simultaneous push and pop with two entries queued.
        for (int i = 0; i < 3; i++)
            step(1'b1, 2'b11, 4'(i), 4'h7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b10, 4'(8 + i), 4'h1, 1'b1);
            check_val("pp_in_ready", 32'(in_ready), 32'd1);
        end
        idle(6, 1'b1);

        // Asynchronous reset while draining a full queue.
        for (int i = 0; i < 5; i++)
            step(1'b1, 2'b01, 4'(i), 4'hE, 1'b0);
        idle(2, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_out_valid", 32'(out_valid), 32'd0);
        check_val("arst_in_ready", 32'(in_ready), 32'd1);
        check_val("arst_issue_cnt", 32'(issue_cnt), 32'd0);
        check_val("arst_alu_code", 32'(alu_code), 32'd0);
        check_val("arst_alu_b", 32'(alu_b), 32'd0);
        mq.delete();
        m_ov = 1'b0; m_res = 5'h00; m_code = 2'b00; m_cnt = '0;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("arst_out_result", 32'(out_result), 32'd0);
        compare_all();
        prev_cnt = issue_cnt;
        idle(3, 1'b1);

        // 257 random ops with random backpressure: counter wraps and ends at 1.
        n_pushed = 0;
        guard = 0;
        while (n_pushed < 257 && guard < 4000) begin
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0));
            guard++;
        end
        idle(DEPTH + 3, 1'b1);
        check_val("rand_cnt_end", 32'(issue_cnt), 32'd1);
        check_val("rand_wrapped", 32'(wrapped), 32'd1);
        check_val("rand_drained", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
